// File: rtl/ppu_pkg.sv
// Shared constants and int8 saturation for the ppu_vec post-processing unit.
// Build option: PPU_ROUND_EN selects round-half-up shifting in ppu_lane.
`ifndef DATA_BITS
`define DATA_BITS 20
`endif

package ppu_pkg;
    localparam int OUT_BITS   = 8;
    localparam int QMIN       = -128;
    localparam int QMAX       = 127;
    localparam int SCALE_BITS = 6;
    localparam int SAT_BITS   = 64;

    function automatic logic signed [OUT_BITS-1:0] sat_int8(input logic signed [SAT_BITS-1:0] v);
        if (v > SAT_BITS'(QMAX)) begin
            return OUT_BITS'(QMAX);
        end else if (v < SAT_BITS'(QMIN)) begin
            return OUT_BITS'(QMIN);
        end else begin
            return v[OUT_BITS-1:0];
        end
    endfunction
endpackage

// File: rtl/ppu_lane.sv
// One lane: optional ReLU, arithmetic right shift (round-half-up when
// PPU_ROUND_EN is defined), int8 saturation and a running signed max.
`ifndef DATA_BITS
`define DATA_BITS 20
`endif

module ppu_lane
    import ppu_pkg::*;
#(
    parameter int DATA_BITS = `DATA_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_BITS-1:0] x,
    input  logic [SCALE_BITS-1:0]       scale,
    input  logic                        relu_en,
    input  logic                        first,
    input  logic                        en,
    input  logic                        clr,
    output logic signed [OUT_BITS-1:0]  res
);
    logic signed [DATA_BITS-1:0] r;
    logic signed [DATA_BITS:0]   wide;
    logic signed [DATA_BITS:0]   shifted;
    logic signed [OUT_BITS-1:0]  q;
    logic signed [OUT_BITS-1:0]  acc_reg;
`ifdef PPU_ROUND_EN
    logic signed [DATA_BITS:0]   bias;
`endif

    always_comb begin
        r    = (relu_en && x[DATA_BITS-1]) ? '0 : x;
        wide = (DATA_BITS+1)'(r);
`ifdef PPU_ROUND_EN
        bias = '0;
        if (scale == '0) begin
            shifted = wide;
        end else if (int'(scale) > DATA_BITS) begin
            // Any input is below half an output step here, so it rounds to zero.
            shifted = '0;
        end else begin
            bias    = (DATA_BITS+1)'(1) << (scale - SCALE_BITS'(1));
            shifted = (wide + bias) >>> scale;
        end
`else
        shifted = wide >>> scale;
`endif
        q   = sat_int8(SAT_BITS'(shifted));
        res = (first || (q > acc_reg)) ? q : acc_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= res;
        end
    end
endmodule

// File: rtl/ppu_vec.sv
// Vector post-processing unit: per-lane ReLU/shift/saturate with max-pooling
// over a window of beats. Build option: PPU_ROUND_EN enables rounding shifts.
`ifndef DATA_BITS
`define DATA_BITS 20
`endif

module ppu_vec
    import ppu_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int DATA_BITS = `DATA_BITS,
    parameter int POOL_MAX  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*DATA_BITS-1:0]        in_data,
    input  logic [SCALE_BITS-1:0]             cfg_scale,
    input  logic                              cfg_relu_en,
    input  logic                              cfg_pool_en,
    input  logic [$clog2(POOL_MAX+1)-1:0]     cfg_pool_size,
    input  logic                              flush,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*OUT_BITS-1:0]         out_data
);
    localparam int CNT_BITS = $clog2(POOL_MAX + 1);

    logic [CNT_BITS-1:0]        cnt_reg;
    logic [SCALE_BITS-1:0]      scale_reg;
    logic                       relu_reg;
    logic                       pool_en_reg;
    logic [CNT_BITS-1:0]        pool_size_reg;
    logic                       out_valid_reg;
    logic [LANES*OUT_BITS-1:0]  out_data_reg;
    logic [LANES*OUT_BITS-1:0]  result;

    logic                       window_start;
    logic                       accept;
    logic                       take;
    logic                       last;
    logic [SCALE_BITS-1:0]      scale_eff;
    logic                       relu_eff;
    logic                       pool_en_eff;
    logic [CNT_BITS-1:0]        pool_size_eff;
    logic [CNT_BITS-1:0]        win;

    assign in_ready  = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;
    assign take      = accept && !flush;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    // The first beat of a window sees the live cfg; later beats use the latched copy.
    always_comb begin
        window_start  = (cnt_reg == '0);
        scale_eff     = window_start ? cfg_scale     : scale_reg;
        relu_eff      = window_start ? cfg_relu_en   : relu_reg;
        pool_en_eff   = window_start ? cfg_pool_en   : pool_en_reg;
        pool_size_eff = window_start ? cfg_pool_size : pool_size_reg;
        if (!pool_en_eff || (pool_size_eff == '0)) begin
            win = CNT_BITS'(1);
        end else if (int'(pool_size_eff) > POOL_MAX) begin
            win = CNT_BITS'(POOL_MAX);
        end else begin
            win = pool_size_eff;
        end
        last = (cnt_reg == (win - CNT_BITS'(1)));
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            ppu_lane #(
                .DATA_BITS(DATA_BITS)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .x       (in_data[gi*DATA_BITS +: DATA_BITS]),
                .scale   (scale_eff),
                .relu_en (relu_eff),
                .first   (window_start),
                .en      (take),
                .clr     (flush),
                .res     (result[gi*OUT_BITS +: OUT_BITS])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg       <= '0;
            scale_reg     <= '0;
            relu_reg      <= 1'b0;
            pool_en_reg   <= 1'b0;
            pool_size_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            // Flush wins over a beat arriving in the same cycle; a pending output is kept.
            if (flush) begin
                cnt_reg <= '0;
            end else if (accept) begin
                if (window_start) begin
                    scale_reg     <= cfg_scale;
                    relu_reg      <= cfg_relu_en;
                    pool_en_reg   <= cfg_pool_en;
                    pool_size_reg <= cfg_pool_size;
                end
                if (last) begin
                    cnt_reg       <= '0;
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= result;
                end else begin
                    cnt_reg <= cnt_reg + CNT_BITS'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ppu_vec.sv
// Directed bench for ppu_vec with an expected-output queue; expectations for
// rounding cases follow PPU_ROUND_EN.
`ifndef DATA_BITS
`define DATA_BITS 20
`endif

module tb_ppu_vec;
    localparam int LANES    = 4;
    localparam int DB       = `DATA_BITS;
    localparam int POOL_MAX = 4;
    localparam int CB       = $clog2(POOL_MAX + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [LANES*DB-1:0]  in_data = '0;
    logic [5:0]           cfg_scale = '0;
    logic                 cfg_relu_en = 1'b0;
    logic                 cfg_pool_en = 1'b0;
    logic [CB-1:0]        cfg_pool_size = '0;
    logic                 flush = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [LANES*8-1:0]   out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    logic [LANES*8-1:0] exp_q[$];

    always #5 clk = ~clk;

    ppu_vec #(
        .LANES(LANES),
        .DATA_BITS(DB),
        .POOL_MAX(POOL_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .cfg_scale     (cfg_scale),
        .cfg_relu_en   (cfg_relu_en),
        .cfg_pool_en   (cfg_pool_en),
        .cfg_pool_size (cfg_pool_size),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LANES*DB-1:0] pin(input int a, input int b, input int c, input int d);
        int t[4];
        logic [LANES*DB-1:0] v;
        t = '{a, b, c, d};
        v = '0;
        for (int i = 0; i < 4; i++) v[i*DB +: DB] = DB'(t[i]);
        return v;
    endfunction

    function automatic logic [LANES*8-1:0] pout(input int a, input int b, input int c, input int d);
        int t[4];
        logic [LANES*8-1:0] v;
        t = '{a, b, c, d};
        v = '0;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(t[i]);
        return v;
    endfunction

    // Inputs change 1 time unit after the rising edge, well away from sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int s, input int relu, input int pen, input int size);
        cfg_scale     = 6'(s);
        cfg_relu_en   = (relu != 0);
        cfg_pool_en   = (pen != 0);
        cfg_pool_size = CB'(size);
    endtask

    task automatic send(input logic [LANES*DB-1:0] d);
        int guard;
        guard    = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_wait", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    // Output side: pop the scoreboard on every handshake.
    always @(negedge clk) begin
        logic [LANES*8-1:0] e;
        if (rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e);
                $display("out beat %0d: data %h expected %h", n_out, out_data, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        rst = 1'b1;
        check("in_ready_after_rst", in_ready, 1'b1);

        // W=1, scale 4: saturation both ways, one-cycle latency
        set_cfg(4, 0, 0, 0);
        exp_q.push_back(pout(16, -16, 127, -128));
        send(pin(256, -256, 524287, -524287));
        check("w1_latency_valid", out_valid, 1'b1);
        tick();
        check("w1_valid_drop", out_valid, 1'b0);

        // ReLU with scale 0
        set_cfg(0, 1, 0, 0);
        exp_q.push_back(pout(0, 5, 127, 0));
        send(pin(-5, 5, 200, -200));
        tick();

        // Larger shift
        set_cfg(8, 0, 0, 0);
`ifdef PPU_ROUND_EN
        exp_q.push_back(pout(127, -128, 4, 0));
`else
        exp_q.push_back(pout(127, -128, 3, -1));
`endif
        send(pin(65536, -32768, 1023, -1));
        tick();

        // Rounding versus truncation at scale 2
        set_cfg(2, 0, 0, 0);
`ifdef PPU_ROUND_EN
        exp_q.push_back(pout(2, -1, 1, -1));
`else
        exp_q.push_back(pout(1, -2, 1, -2));
`endif
        send(pin(6, -6, 5, -5));
        tick();

        // Pool of 4 with cfg changed after the first beat (must be ignored)
        set_cfg(0, 0, 1, 4);
        send(pin(3, -1, 100, -200));
        check("pool_b1_quiet", out_valid, 1'b0);
        set_cfg(4, 1, 0, 1);
        send(pin(-7, -2, 200, -200));
        check("pool_b2_quiet", out_valid, 1'b0);
        send(pin(9, -3, 50, -200));
        check("pool_b3_quiet", out_valid, 1'b0);
        exp_q.push_back(pout(9, -1, 127, -128));
        send(pin(1, -4, 0, -200));
        check("pool_done_valid", out_valid, 1'b1);
        tick();

        // Flush after two beats, with a beat in the flush cycle
        set_cfg(0, 0, 1, 4);
        send(pin(100, 100, 100, 100));
        send(pin(100, 100, 100, 100));
        in_data  = pin(50, 50, 50, 50);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_quiet", out_valid, 1'b0);
        exp_q.push_back(pout(2, 2, 2, 2));
        for (int i = 0; i < 4; i++) begin
            send(pin(2, 2, 2, 2));
            if (i < 3) check("post_flush_quiet", out_valid, 1'b0);
        end
        check("post_flush_valid", out_valid, 1'b1);
        tick();

        // Pool size above POOL_MAX clamps to POOL_MAX
        set_cfg(0, 0, 1, 7);
        for (int i = 1; i <= 3; i++) begin
            send(pin(i, -i, 10 * i, -10 * i));
            check("clamp_quiet", out_valid, 1'b0);
        end
        exp_q.push_back(pout(4, -1, 40, -10));
        send(pin(4, -4, 40, -40));
        check("clamp_valid", out_valid, 1'b1);
        tick();

        // Pool enabled with size 0 behaves as W=1
        set_cfg(0, 0, 1, 0);
        exp_q.push_back(pout(7, 7, 7, 7));
        send(pin(7, 7, 7, 7));
        check("size0_valid", out_valid, 1'b1);
        tick();

        // Back-to-back stream at one beat per cycle
        set_cfg(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pout(i, i + 1, -i, 10));
            in_data  = pin(i, i + 1, -i, 10);
            in_valid = 1'b1;
            check("stream_ready", in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // Output stall for 5 cycles with the next beat waiting
        out_ready = 1'b0;
        exp_q.push_back(pout(1, 2, 3, 4));
        send(pin(1, 2, 3, 4));
        exp_q.push_back(pout(5, 6, 7, 8));
        in_data  = pin(5, 6, 7, 8);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_data", out_data, pout(1, 2, 3, 4));
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("stall_next_valid", out_valid, 1'b1);
        check("stall_next_data", out_data, pout(5, 6, 7, 8));
        tick();
        check("stall_drain", out_valid, 1'b0);

        // Reset mid-window discards the partial max
        set_cfg(0, 0, 1, 2);
        send(pin(100, 100, 100, 100));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_valid", out_valid, 1'b0);
        exp_q.push_back(pout(1, 1, 1, 1));
        send(pin(1, 1, 1, 1));
        check("midrst_quiet", out_valid, 1'b0);
        send(pin(1, 1, 1, 1));
        check("midrst_done", out_valid, 1'b1);
        tick();

        // Reset with an output pending drops it
        set_cfg(0, 0, 0, 0);
        out_ready = 1'b0;
        send(pin(9, 9, 9, 9));
        check("pending_valid", out_valid, 1'b1);
        rst = 1'b0;
        tick();
        check("pending_rst_valid", out_valid, 1'b0);
        check("pending_rst_data", out_data, '0);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
